// File: rtl/manual_drive_pkg.sv
// Shared types and helpers for the manual-drive command path.
package manual_drive_pkg;

    // Enum value doubles as the bit index in the one-hot drive vector.
    typedef enum logic [3:0] {
        DirW    = 4'd0,
        DirS    = 4'd1,
        DirA    = 4'd2,
        DirD    = 4'd3,
        DirWa   = 4'd4,
        DirWd   = 4'd5,
        DirAs   = 4'd6,
        DirDs   = 4'd7,
        DirStop = 4'd8
    } drive_dir_t;

    typedef enum logic [1:0] {
        StStop,
        StDrive,
        StBrake,
        StTimeout
    } ctrl_state_t;

    // One-hot bit order {stop, ds, as, wd, wa, d, a, s, w}, bit0 = w.
    localparam int unsigned DIR_W = 9;
    localparam logic [DIR_W-1:0] DIR_STOP_OH = 9'h100;

    function automatic logic [DIR_W-1:0] dir_onehot(input drive_dir_t d);
        logic [DIR_W-1:0] one;
        one = {{(DIR_W-1){1'b0}}, 1'b1};
        return one << d;
    endfunction

    // hi_set flags any command bit above bit 3; such commands mean Stop.
    function automatic drive_dir_t decode_cmd(input logic [3:0] nib, input logic hi_set);
        drive_dir_t d;
        d = DirStop;
        if (!hi_set) begin
            case (nib)
                4'h1, 4'hA: d = DirW;
                4'h4:       d = DirS;
                4'h2:       d = DirA;
                4'h8:       d = DirD;
                4'h3:       d = DirWa;
                4'h9:       d = DirWd;
                4'h5:       d = DirAs;
                4'hC:       d = DirDs;
                default:    d = DirStop;
            endcase
        end
        return d;
    endfunction

    function automatic logic is_fwd(input drive_dir_t d);
        return (d == DirW) || (d == DirWa) || (d == DirWd);
    endfunction

    function automatic logic is_back(input drive_dir_t d);
        return (d == DirS) || (d == DirAs) || (d == DirDs);
    endfunction

endpackage

// File: rtl/cmd_stability_filter.sv
// Consecutive-match filter: a direction is accepted only after STABLE_CNT
// matching strobes; Stop is accepted on its first strobe.
module cmd_stability_filter
    import manual_drive_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       valid_i,
    input  drive_dir_t dir_i,
    output drive_dir_t cand_o,
    output logic       accept_o
);

    localparam int unsigned CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    drive_dir_t    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reached;

    // Candidate/count update and accept pulse.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        reached  = 1'b0;
        accept_o = 1'b0;
        if (clear_i) begin
            cand_d = DirStop;
            cnt_d  = '0;
        end else if (valid_i) begin
            if (dir_i == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                // A saturated count does not re-fire.
                reached = (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);
            end else begin
                cand_d  = dir_i;
                cnt_d   = CNT_ONE;
                reached = (CNT_ONE == CNT_MAX);
            end
            accept_o = reached || (dir_i == DirStop);
        end
    end

    // Candidate is exposed as its next value so it matches the accept pulse.
    assign cand_o = cand_d;

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= DirStop;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-drive controller: filtered command decode, link-loss watchdog and
// reversal brake interval feeding a registered one-hot direction vector.
module manual_drive_ctrl
    import manual_drive_pkg::*;
#(
    parameter int unsigned CMD_W       = 8,
    parameter int unsigned STABLE_CNT  = 3,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned BRAKE_CYC   = 5_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd_i,
    input  logic             cmd_valid_i,
    input  logic             manual_on_i,
    output logic [DIR_W-1:0] dir_o,
    output logic             timeout_o,
    output logic             braking_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BR_W = $clog2(BRAKE_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [BR_W-1:0] BR_LAST = BR_W'(BRAKE_CYC - 1);

    ctrl_state_t      state_q, state_d;
    drive_dir_t       active_q, active_d;
    drive_dir_t       pending_q, pending_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [BR_W-1:0]  brake_q, brake_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             timeout_q, timeout_d;
    logic             braking_q, braking_d;

    logic       hi_set;
    drive_dir_t dec;
    drive_dir_t cand;
    logic       accept;
    logic       strobe;
    logic       expire;
    logic       reverse;

    assign hi_set = (cmd_i >> 4) != '0;
    assign dec    = decode_cmd(cmd_i[3:0], hi_set);
    assign strobe = cmd_valid_i && manual_on_i;

    cmd_stability_filter #(
        .STABLE_CNT (STABLE_CNT)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!manual_on_i),
        .valid_i  (strobe),
        .dir_i    (dec),
        .cand_o   (cand),
        .accept_o (accept)
    );

    // Watchdog: cleared by any strobe, otherwise counts up and saturates.
    always_comb begin
        wd_d = wd_q;
        if (!manual_on_i || cmd_valid_i) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // A strobe in the expiry cycle clears the watchdog, so it wins.
    assign expire  = manual_on_i && !cmd_valid_i && (wd_q == WD_LAST);
    assign reverse = (is_fwd(cand) && is_back(active_q)) ||
                     (is_back(cand) && is_fwd(active_q));

    // Control FSM next-state, active/pending direction and brake counter.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        brake_d   = brake_q;
        if (!manual_on_i) begin
            state_d = StStop;
            brake_d = '0;
        end else if (expire) begin
            state_d = StTimeout;
            brake_d = '0;
        end else begin
            unique case (state_q)
                StStop, StTimeout: begin
                    if (accept && cand != DirStop) begin
                        state_d  = StDrive;
                        active_d = cand;
                    end
                end
                StDrive: begin
                    if (accept) begin
                        if (cand == DirStop) begin
                            state_d = StStop;
                        end else if (reverse) begin
                            state_d   = StBrake;
                            pending_d = cand;
                            brake_d   = '0;
                        end else begin
                            active_d = cand;
                        end
                    end
                end
                StBrake: begin
                    if (accept && cand == DirStop) begin
                        state_d = StStop;
                        brake_d = '0;
                    end else begin
                        if (accept) begin
                            pending_d = cand;
                        end
                        if (brake_q == BR_LAST) begin
                            state_d  = StDrive;
                            active_d = pending_d;
                            brake_d  = '0;
                        end else begin
                            brake_d = brake_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they move with the state.
    always_comb begin
        dir_d     = '0;
        timeout_d = 1'b0;
        braking_d = 1'b0;
        if (manual_on_i) begin
            dir_d     = (state_d == StDrive) ? dir_onehot(active_d) : DIR_STOP_OH;
            timeout_d = (state_d == StTimeout);
            braking_d = (state_d == StBrake);
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StStop;
            active_q  <= DirStop;
            pending_q <= DirStop;
            wd_q      <= '0;
            brake_q   <= '0;
            dir_q     <= '0;
            timeout_q <= 1'b0;
            braking_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            wd_q      <= wd_d;
            brake_q   <= brake_d;
            dir_q     <= dir_d;
            timeout_q <= timeout_d;
            braking_q <= braking_d;
        end
    end

    assign dir_o     = dir_q;
    assign timeout_o = timeout_q;
    assign braking_o = braking_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Bench for manual_drive_ctrl: vector table plus hand-written corner sequences.
module tb_manual_drive_ctrl;

    localparam logic [8:0] S  = 9'h100;
    localparam logic [8:0] W  = 9'h001;
    localparam logic [8:0] A  = 9'h004;
    localparam logic [8:0] D  = 9'h008;
    localparam logic [8:0] DS = 9'h080;

    typedef struct {
        logic [7:0] cmd;
        logic       v;
        logic       mon;
        logic [8:0] dir;
        logic       to;
        logic       br;
    } vec_t;

    typedef struct {
        logic [8:0] dir;
        logic       to;
        logic       br;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd_i;
    logic       cmd_valid_i;
    logic       manual_on_i;
    logic [8:0] dir_o;
    logic       timeout_o;
    logic       braking_o;

    exp_t sb[$];
    vec_t tbl[29];
    int   total = 0;
    int   bad   = 0;

    manual_drive_ctrl #(
        .CMD_W       (8),
        .STABLE_CNT  (3),
        .TIMEOUT_CYC (20),
        .BRAKE_CYC   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_i       (cmd_i),
        .cmd_valid_i (cmd_valid_i),
        .manual_on_i (manual_on_i),
        .dir_o       (dir_o),
        .timeout_o   (timeout_o),
        .braking_o   (braking_o)
    );

    always #5 clk = ~clk;

    task automatic check_now(input logic [8:0] ed, input logic et, input logic eb,
                             input string name);
        total++;
        if (dir_o !== ed || timeout_o !== et || braking_o !== eb) begin
            bad++;
            $display("FAIL %s: got dir=%h timeout=%b braking=%b, want dir=%h timeout=%b braking=%b",
                     name, dir_o, timeout_o, braking_o, ed, et, eb);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic cyc(input logic [7:0] c, input logic v, input logic m,
                       input logic [8:0] ed, input logic et, input logic eb,
                       input string name);
        exp_t e;
        cmd_i       = c;
        cmd_valid_i = v;
        manual_on_i = m;
        e.dir  = ed;
        e.to   = et;
        e.br   = eb;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        e = sb.pop_front();
        check_now(e.dir, e.to, e.br, e.name);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running, want finished");
        $fatal(1, "time limit");
    end

    initial begin
        tbl[0]  = '{8'h00, 1'b0, 1'b1, S,  1'b0, 1'b0};
        tbl[1]  = '{8'h01, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[2]  = '{8'h01, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[3]  = '{8'h01, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, W,  1'b0, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[6]  = '{8'h01, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[7]  = '{8'h01, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[8]  = '{8'h02, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b1, S,  1'b0, 1'b0};
        tbl[10] = '{8'h01, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[11] = '{8'h01, 1'b1, 1'b1, S,  1'b0, 1'b0};
        tbl[12] = '{8'h01, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[13] = '{8'h0C, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[14] = '{8'h0C, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[15] = '{8'h0C, 1'b1, 1'b1, S,  1'b0, 1'b1};
        tbl[16] = '{8'h00, 1'b0, 1'b1, S,  1'b0, 1'b1};
        tbl[17] = '{8'h00, 1'b0, 1'b1, S,  1'b0, 1'b1};
        tbl[18] = '{8'h00, 1'b0, 1'b1, S,  1'b0, 1'b1};
        tbl[19] = '{8'h00, 1'b0, 1'b1, DS, 1'b0, 1'b0};
        tbl[20] = '{8'h02, 1'b1, 1'b1, DS, 1'b0, 1'b0};
        tbl[21] = '{8'h02, 1'b1, 1'b1, DS, 1'b0, 1'b0};
        tbl[22] = '{8'h02, 1'b1, 1'b1, A,  1'b0, 1'b0};
        tbl[23] = '{8'h01, 1'b1, 1'b1, A,  1'b0, 1'b0};
        tbl[24] = '{8'h01, 1'b1, 1'b1, A,  1'b0, 1'b0};
        tbl[25] = '{8'h01, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[26] = '{8'h02, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[27] = '{8'h02, 1'b1, 1'b1, W,  1'b0, 1'b0};
        tbl[28] = '{8'h02, 1'b1, 1'b1, A,  1'b0, 1'b0};

        rst_n       = 1'b0;
        cmd_i       = '0;
        cmd_valid_i = 1'b0;
        manual_on_i = 1'b1;
        #3;
        check_now(9'h000, 1'b0, 1'b0, "reset_values");
        #9;
        rst_n = 1'b1;
        cyc(8'h00, 1'b0, 1'b1, S, 1'b0, 1'b0, "stop_after_reset_release");

        for (int i = 0; i < 29; i++) begin
            cyc(tbl[i].cmd, tbl[i].v, tbl[i].mon, tbl[i].dir, tbl[i].to, tbl[i].br,
                $sformatf("vec%0d", i));
        end

        // Link loss: 20th idle cycle after the last strobe trips the watchdog.
        for (int i = 0; i < 19; i++) begin
            cyc(8'h00, 1'b0, 1'b1, A, 1'b0, 1'b0, $sformatf("idle_pre_timeout%0d", i));
        end
        cyc(8'h00, 1'b0, 1'b1, S, 1'b1, 1'b0, "timeout_rise");
        cyc(8'h00, 1'b0, 1'b1, S, 1'b1, 1'b0, "timeout_hold");
        cyc(8'h08, 1'b1, 1'b1, S, 1'b1, 1'b0, "timeout_exit_1");
        cyc(8'h08, 1'b1, 1'b1, S, 1'b1, 1'b0, "timeout_exit_2");
        cyc(8'h08, 1'b1, 1'b1, D, 1'b0, 1'b0, "timeout_exit_right");

        // Out-of-range code decodes to Stop and keeps feeding the watchdog.
        for (int i = 0; i < 15; i++) begin
            cyc(8'h11, 1'b1, 1'b1, S, 1'b0, 1'b0, $sformatf("invalid_strobe%0d", i));
            cyc(8'h00, 1'b0, 1'b1, S, 1'b0, 1'b0, $sformatf("invalid_gap%0d", i));
        end

        // Drop manual_on mid-brake, then check the filter restarted from scratch.
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b0, "fwd_1");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b0, "fwd_2");
        cyc(8'h01, 1'b1, 1'b1, W, 1'b0, 1'b0, "fwd_3");
        cyc(8'h05, 1'b1, 1'b1, W, 1'b0, 1'b0, "lb_1");
        cyc(8'h05, 1'b1, 1'b1, W, 1'b0, 1'b0, "lb_2");
        cyc(8'h05, 1'b1, 1'b1, S, 1'b0, 1'b1, "lb_brake");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b1, "brake_fwd_1");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b1, "brake_fwd_2");
        cyc(8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, "manual_off");
        cyc(8'h01, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, "manual_off_strobe");
        cyc(8'h00, 1'b0, 1'b1, S, 1'b0, 1'b0, "manual_on_again");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b0, "fresh_fwd_1");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b0, "fresh_fwd_2");
        cyc(8'h01, 1'b1, 1'b1, W, 1'b0, 1'b0, "fresh_fwd_3");

        // Strobe landing exactly on the expiry cycle suppresses the timeout.
        cyc(8'h00, 1'b1, 1'b1, S, 1'b0, 1'b0, "stop_before_ds");
        cyc(8'h0C, 1'b1, 1'b1, S, 1'b0, 1'b0, "ds_1");
        cyc(8'h0C, 1'b1, 1'b1, S, 1'b0, 1'b0, "ds_2");
        cyc(8'h0C, 1'b1, 1'b1, DS, 1'b0, 1'b0, "ds_3");
        for (int i = 0; i < 19; i++) begin
            cyc(8'h00, 1'b0, 1'b1, DS, 1'b0, 1'b0, $sformatf("idle_edge%0d", i));
        end
        cyc(8'h0C, 1'b1, 1'b1, DS, 1'b0, 1'b0, "strobe_at_expiry");
        cyc(8'h00, 1'b0, 1'b1, DS, 1'b0, 1'b0, "after_expiry_strobe");

        // Asynchronous reset in the middle of a filter count.
        cyc(8'h01, 1'b1, 1'b1, DS, 1'b0, 1'b0, "pre_rst_1");
        cyc(8'h01, 1'b1, 1'b1, DS, 1'b0, 1'b0, "pre_rst_2");
        #2;
        rst_n = 1'b0;
        #1;
        check_now(9'h000, 1'b0, 1'b0, "async_reset_mid_count");
        #1;
        rst_n = 1'b1;
        cyc(8'h00, 1'b0, 1'b1, S, 1'b0, 1'b0, "post_rst_stop");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b0, "post_rst_fwd_1");
        cyc(8'h01, 1'b1, 1'b1, S, 1'b0, 1'b0, "post_rst_fwd_2");
        cyc(8'h01, 1'b1, 1'b1, W, 1'b0, 1'b0, "post_rst_fwd_3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/manual_drive_ctrl.md
# manual_drive_ctrl

Parametrised successor to the single-cycle manual command decoder. It turns the 8-bit Arduino manual-drive command stream into a registered, one-hot drive direction. It adds three things on top of plain decoding: a consecutive-match stability filter, a link-loss watchdog that forces Stop, and a mandatory brake interval whenever travel reverses. It sits between the Arduino command receiver and the motor-direction mux, and is active only while manual mode is selected.

## Interface
- `CMD_W`, 8: command width. Only bits [3:0] are decoded; any set bit above bit 3 decodes to Stop.
- `STABLE_CNT`, 3: number of consecutive `cmd_valid` strobes with the same non-Stop decode required before the direction is accepted. Must be ≥1.
- `TIMEOUT_CYC`, 50_000_000: number of clk cycles without `cmd_valid` before a forced Stop.
- `BRAKE_CYC`, 5_000_000: number of Stop cycles inserted on a forward↔backward reversal.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cmd`, in, CMD_W: command byte from the receiver. Sampled only when `cmd_valid` is high.
- `cmd_valid`, in, 1: single-cycle strobe marking a new command.
- `manual_on`, in, 1: manual-mode enable.
- `dir`, out, 9: registered one-hot drive vector, bit order {stop, ds, as, wd, wa, d, a, s, w} (bit0 = w). All-zero when `manual_on` = 0.
- `timeout`, out, 1: high while in TIMEOUT.
- `braking`, out, 1: high while in BRAKE.

## Operation
Decode of `cmd`:
- 0x01 and 0x0A → Forward
- 0x04 → Backward
- 0x02 → Left
- 0x08 → Right
- 0x03 → LeftFwd
- 0x09 → RightFwd
- 0x05 → LeftBack
- 0x0C → RightBack
- 0x00 and every other value → Stop

Direction families:
- Forward family: Forward, LeftFwd, RightFwd.
- Backward family: Backward, LeftBack, RightBack.
- Left and Right are neutral.

Stability filter:
- Holds a candidate direction and a match count.
- On `cmd_valid`, if the decode equals the candidate, the count increments (saturating at STABLE_CNT). Otherwise the candidate becomes the new decode and the count becomes 1.
- An accept pulse fires in the cycle the count reaches STABLE_CNT.
- A Stop decode bypasses the filter and accepts on its first strobe.

State machine (STOP, DRIVE, BRAKE, TIMEOUT); `active` is the current drive direction:
- STOP: accept of direction X → DRIVE with active = X.
- DRIVE:
  - Accept of Stop → STOP.
  - Accept of X where X and active are in opposite families → BRAKE; X is latched as pending.
  - Any other accept of X → DRIVE with active = X.
- BRAKE:
  - `dir` = stop.
  - The brake counter runs for BRAKE_CYC cycles, then the state goes to DRIVE with active = pending.
  - An accept during BRAKE replaces pending. An accepted Stop ends BRAKE and goes to STOP immediately.
- TIMEOUT:
  - `dir` = stop.
  - Exits only on an accept of a non-Stop X → DRIVE with active = X. No brake is applied on this exit.
- Any state: the watchdog reaching TIMEOUT_CYC → TIMEOUT. This takes priority over every other transition in the same cycle.

Watchdog:
- Counter clears on every `cmd_valid`, including invalid codes, and otherwise increments.
- Saturates at TIMEOUT_CYC.

Output mapping:
- STOP, BRAKE and TIMEOUT drive the stop bit.
- DRIVE drives the bit for `active`.

`manual_on` = 0:
- State forced to STOP; filter, watchdog and brake counters cleared.
- `dir`, `timeout` and `braking` are 0.
- Strobes are ignored while `manual_on` is low.

## Timing
- Reset values: state STOP, all counters 0, `dir` = 0, `timeout` = 0, `braking` = 0.
- `dir` = stop one cycle after reset release if `manual_on` = 1.
- Latency: the Nth matching `cmd_valid` at cycle t gives the accept at t. The state and `dir` update at t+1.
- Stop latency: one cycle from its first strobe.
- Watchdog: with the last `cmd_valid` at cycle t, `timeout` rises at t+TIMEOUT_CYC+1.
- Brake: `braking` is high for exactly BRAKE_CYC cycles. The new direction appears on the following cycle.
- Simultaneous `cmd_valid` and watchdog expiry: the strobe clears the watchdog, so no timeout occurs.
- Counter widths: `$clog2(max+1)` each. No wrap-around, because all counters saturate or clear.
- `rst_n` asserted mid-BRAKE or mid-count: all outputs reach their reset values immediately (asynchronous).

## Structure
- `manual_drive_pkg` contains:
  - the `drive_dir_t` enum (9 values);
  - the `ctrl_state_t` enum;
  - a `decode_cmd()` function;
  - an `is_fwd()` / `is_back()` family function;
  - an encoding localparam for the one-hot bit order.
- Sub-module `cmd_stability_filter`, parametrised by STABLE_CNT, produces the candidate and accept outputs.
- The top level holds the FSM, the watchdog and the brake counter.

## Test plan
- STABLE_CNT=3: three strobes of 0x01 → `dir` = 0x001 the cycle after the third strobe. Two strobes of 0x01 followed by one of 0x02 → `dir` stays stop.
- In DRIVE Forward, a single strobe of 0x00 → `dir` = 0x100 (stop) after one cycle.
- In DRIVE Forward, three strobes of 0x0C → `braking` = 1 and `dir` = stop for BRAKE_CYC cycles, then `dir` = 0x080 (ds). Going Forward → Left (0x02) applies no brake.
- TIMEOUT_CYC=20: no strobes for 21 cycles → `timeout` = 1 and `dir` = stop. Then three strobes of 0x08 → `dir` = 0x008 with no brake.
- Invalid code 0x11 strobed repeatedly → stop, and the watchdog never expires.
- Drop `manual_on` mid-BRAKE → `dir` = 0 next cycle. Raise it again → `dir` = stop with a fresh filter. Assert `rst_n` low mid-count → outputs 0 immediately.
